dds_phase_gen: RTL
==================

DDS_PHASE_GEN -- requirements
Module: dds_phase_gen

Interface
REQ-001 SHALL have parameter ACC_W, default 32, phase accumulator width.
REQ-002 SHALL have parameter ADDR_W, default 10, sine ROM address width; addresses the top ADDR_W accumulator bits.
REQ-003 SHALL have parameter DATA_W, default 10, sine sample width.
REQ-004 SHALL have parameter DIV_W, default 16, rate divider width.
REQ-005 SHALL have port clk, input, 1, the only clock; all state on rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port en, input, 1, run enable.
REQ-008 SHALL have port rate_div, input, DIV_W, one sample tick every rate_div+1 enabled cycles.
REQ-009 SHALL have ports ftw, input, ACC_W; ftw_valid, input, 1; ftw_ready, output, 1; the frequency tuning word handshake.
REQ-010 SHALL have port phase_clr, input, 1, synchronous accumulator clear.
REQ-011 SHALL have ports rom_addr, output, ADDR_W and rom_data, input, DATA_W, connecting to the combinational sine ROM.
REQ-012 SHALL have ports sample, output, DATA_W; sample_valid, output, 1; wrap, output, 1.

Function
REQ-013 SHALL keep a counter 0..rate_div; tick = en && (cnt >= rate_div); on tick cnt<=0, else if en cnt<=cnt+1.
REQ-014 SHALL, when rate_div is lowered below cnt, tick on the next enabled cycle; no runaway count.
REQ-015 SHALL, with en=0, hold cnt, accumulator and pending word and generate no tick; in-flight samples still complete.
REQ-016 SHALL, on tick, set acc <= acc + step mod 2^ACC_W, where step = pending word if present, else ftw_active.
REQ-017 SHALL, on a tick consuming a pending word, load ftw_active with it and clear pending.
REQ-018 SHALL accept ftw when ftw_valid && ftw_ready, capturing it as the pending word and driving ftw_ready=0 next cycle.
REQ-019 SHALL re-assert ftw_ready in the cycle after the consuming tick.
REQ-020 SHALL not let a word accepted in a tick cycle affect that tick; it applies at the following tick.
REQ-021 SHALL drive rom_addr combinationally from acc[ACC_W-1:ACC_W-ADDR_W].
REQ-022 SHALL register rom_data into sample one cycle after the tick edge, with sample_valid=1 for exactly one cycle; tick in cycle T gives sample_valid in cycle T+2.
REQ-023 SHALL hold sample between valid pulses.
REQ-024 SHALL register the addition carry-out and assert wrap in the same cycle as the sample_valid of that step.
REQ-025 SHALL, on phase_clr, set acc<=0 with priority over a same-cycle tick; cnt, the pending word and the handshake are unaffected; no sample is emitted for the suppressed tick.

Reset
REQ-026 SHALL, on rst_n low, asynchronously clear acc, cnt, ftw_active, the pipeline and the pending flag.
REQ-027 SHALL, in reset, drive sample=0, sample_valid=0, wrap=0, rom_addr=0 and ftw_ready=1.
REQ-028 SHALL release reset cleanly mid-operation, discarding any pending word and in-flight sample.

Configuration
REQ-029 SHALL, when macro DDS_PHASE_OFFSET_EN is defined, add input phase_off (ADDR_W) and drive rom_addr = acc top bits + phase_off mod 2^ADDR_W, with no added latency.
REQ-030 SHALL, without DDS_PHASE_OFFSET_EN, omit the phase_off port and drive rom_addr per REQ-021.

Structure
REQ-031 SHALL take default widths and the ROM depth constant (2^ADDR_W) from shared package dds_pkg.
REQ-032 SHALL place the counter/tick logic of REQ-013..REQ-015 in sub-module dds_rate_div.

Verification
REQ-033 Reset: hold rst_n=0 with en=1 and ftw_valid=1 -> all outputs 0 and ftw_ready=1.
REQ-034 Step: ftw=0x00400000 loaded, rate_div=0, en=1 -> rom_addr increments by 1 per cycle; sample_valid every cycle; wrap once per 1024 samples.
REQ-035 Rate: rate_div=4 -> sample_valid one cycle in five; en low for 7 cycles stretches the gap by 7.
REQ-036 Retune: ftw=0x01000000 offered mid-run with rate_div=3 -> ftw_ready low until the cycle after the next tick; address step then 4.
REQ-037 Clear: phase_clr coincident with tick, acc=0x80000000 -> acc=0, no sample_valid from that tick.
REQ-038 Offset (DDS_PHASE_OFFSET_EN): phase_off=256, acc top bits=1023 -> rom_addr=255.

Source files
------------

// File: rtl/dds_pkg.sv
// Shared defaults for the DDS phase generator: accumulator, ROM address,
// sample and rate-divider widths, plus the sine ROM depth derived from them.
package dds_pkg;

    localparam int DDS_ACC_W  = 32;
    localparam int DDS_ADDR_W = 10;
    localparam int DDS_DATA_W = 10;
    localparam int DDS_DIV_W  = 16;

    // Number of entries in the sine ROM addressed by the top accumulator bits.
    localparam int DDS_ROM_DEPTH = 1 << DDS_ADDR_W;

    // Depth of a ROM with the given address width, for non-default builds.
    function automatic int rom_depth(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/dds_rate_div.sv
// Sample-rate divider: produces one tick every rate_div+1 enabled cycles.
// Uses >= in the compare so lowering rate_div below the running count
// fires on the next enabled cycle instead of counting through the wrap.
module dds_rate_div
    import dds_pkg::*;
#(
    parameter int DIV_W = DDS_DIV_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [DIV_W-1:0] rate_div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    assign tick = en && (cnt_q >= rate_div);

    // Next count: restart on tick, advance while enabled, otherwise hold.
    always_comb begin
        cnt_d = cnt_q;
        if (tick) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dds_phase_gen.sv
// DDS phase generator: phase accumulator with a one-deep tuning-word buffer,
// rate-divided stepping and a two-stage sample pipeline around an external
// combinational sine ROM.
// Optional feature: define DDS_PHASE_OFFSET_EN to add the phase_off input,
// which is added to the ROM address with no extra latency.
module dds_phase_gen
    import dds_pkg::*;
#(
    parameter int ACC_W  = DDS_ACC_W,
    parameter int ADDR_W = DDS_ADDR_W,
    parameter int DATA_W = DDS_DATA_W,
    parameter int DIV_W  = DDS_DIV_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [DIV_W-1:0]  rate_div,
    input  logic [ACC_W-1:0]  ftw,
    input  logic              ftw_valid,
    output logic              ftw_ready,
    input  logic              phase_clr,
`ifdef DDS_PHASE_OFFSET_EN
    input  logic [ADDR_W-1:0] phase_off,
`endif
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] sample,
    output logic              sample_valid,
    output logic              wrap
);

    logic              tick;
    logic              step_en;
    logic              accept;
    logic [ACC_W-1:0]  step;
    logic [ACC_W:0]    sum_full;

    logic [ACC_W-1:0]  acc_q,        acc_d;
    logic [ACC_W-1:0]  ftw_active_q, ftw_active_d;
    logic [ACC_W-1:0]  pend_word_q,  pend_word_d;
    logic              pend_valid_q, pend_valid_d;
    logic              stg_valid_q,  stg_valid_d;
    logic              stg_carry_q,  stg_carry_d;
    logic [DATA_W-1:0] sample_q,     sample_d;
    logic              out_valid_q,  out_valid_d;
    logic              out_wrap_q,   out_wrap_d;

    dds_rate_div #(
        .DIV_W (DIV_W)
    ) u_rate_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .rate_div (rate_div),
        .tick     (tick)
    );

    // A clear in the tick cycle swallows the step entirely: no phase advance,
    // no word consumption and no sample.
    assign step_en   = tick && !phase_clr;
    assign ftw_ready = !pend_valid_q;
    assign accept    = ftw_valid && ftw_ready;
    assign step      = pend_valid_q ? pend_word_q : ftw_active_q;
    assign sum_full  = {1'b0, acc_q} + {1'b0, step};

`ifdef DDS_PHASE_OFFSET_EN
    assign rom_addr = acc_q[ACC_W-1 -: ADDR_W] + phase_off;
`else
    assign rom_addr = acc_q[ACC_W-1 -: ADDR_W];
`endif

    assign sample       = sample_q;
    assign sample_valid = out_valid_q;
    assign wrap         = out_wrap_q;

    // Next-state for accumulator, tuning-word buffer and sample pipeline.
    always_comb begin
        acc_d        = acc_q;
        ftw_active_d = ftw_active_q;
        pend_word_d  = pend_word_q;
        pend_valid_d = pend_valid_q;

        if (phase_clr) begin
            acc_d = '0;
        end else if (step_en) begin
            acc_d = sum_full[ACC_W-1:0];
        end

        // A pending word is used by the step that consumes it, then retired.
        if (step_en && pend_valid_q) begin
            ftw_active_d = pend_word_q;
            pend_valid_d = 1'b0;
        end

        // Acceptance only happens while the buffer is empty, so it never
        // collides with a consumption in the same cycle.
        if (accept) begin
            pend_word_d  = ftw;
            pend_valid_d = 1'b1;
        end

        // Stage 1 marks the step; the ROM sees the new address during it.
        stg_valid_d = step_en;
        stg_carry_d = step_en && sum_full[ACC_W];

        // Stage 2 captures the ROM word and presents it with its carry.
        sample_d    = stg_valid_q ? rom_data : sample_q;
        out_valid_d = stg_valid_q;
        out_wrap_d  = stg_valid_q && stg_carry_q;
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q        <= '0;
            ftw_active_q <= '0;
            pend_word_q  <= '0;
            pend_valid_q <= 1'b0;
            stg_valid_q  <= 1'b0;
            stg_carry_q  <= 1'b0;
            sample_q     <= '0;
            out_valid_q  <= 1'b0;
            out_wrap_q   <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            ftw_active_q <= ftw_active_d;
            pend_word_q  <= pend_word_d;
            pend_valid_q <= pend_valid_d;
            stg_valid_q  <= stg_valid_d;
            stg_carry_q  <= stg_carry_d;
            sample_q     <= sample_d;
            out_valid_q  <= out_valid_d;
            out_wrap_q   <= out_wrap_d;
        end
    end

endmodule
